// File: rtl/video_timing_pkg.sv
// Shared raster constants, coordinate widths and pattern mode encodings.
package video_timing_pkg;

    localparam int HCNT_W = 11;
    localparam int VCNT_W = 12;
    localparam int MODE_W = 4;
    localparam int POS_W  = 12;

    // CEA 1080p60: 2200 x 1125 total
    localparam int P1080_H_ACTIVE = 1920;
    localparam int P1080_H_FP     = 88;
    localparam int P1080_H_SYNC   = 44;
    localparam int P1080_H_BP     = 148;
    localparam int P1080_V_ACTIVE = 1080;
    localparam int P1080_V_FP     = 4;
    localparam int P1080_V_SYNC   = 5;
    localparam int P1080_V_BP     = 36;

    // CEA 720p60: 1650 x 750 total
    localparam int P720_H_ACTIVE = 1280;
    localparam int P720_H_FP     = 110;
    localparam int P720_H_SYNC   = 40;
    localparam int P720_H_BP     = 220;
    localparam int P720_V_ACTIVE = 720;
    localparam int P720_V_FP     = 5;
    localparam int P720_V_SYNC   = 5;
    localparam int P720_V_BP     = 20;

    typedef enum logic [MODE_W-1:0] {
        MODE_WHITE = 4'd0,
        MODE_GREY  = 4'd1,
        MODE_VBARS = 4'd2
    } pat_mode_e;

    function automatic int span_total(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// DEPTH-stage shift register with clock enable and synchronous clear.
// DEPTH=0 degenerates to a wire.
module sync_delay_line #(
    parameter int DEPTH = 1,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_pipe
        logic [DEPTH-1:0][W-1:0] stage;

        // shift one stage per enabled clock; reset flushes every stage
        always_ff @(posedge clk) begin
            if (rst) begin
                stage <= '0;
            end else if (en) begin
                stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign q = stage[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: active-area coordinates, frame-locked mode,
// and syncs/de delayed to line up with the downstream registered RGB.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = P1080_H_ACTIVE,
    parameter int H_FP     = P1080_H_FP,
    parameter int H_SYNC   = P1080_H_SYNC,
    parameter int H_BP     = P1080_H_BP,
    parameter int V_ACTIVE = P1080_V_ACTIVE,
    parameter int V_FP     = P1080_V_FP,
    parameter int V_SYNC   = P1080_V_SYNC,
    parameter int V_BP     = P1080_V_BP,
    parameter int PIPE_DLY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode_in,
    output logic [HCNT_W-1:0] hcnt,
    output logic [VCNT_W-1:0] vcnt,
    output logic [MODE_W-1:0] mode,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              frame_start,
    output logic [7:0]        frame_cnt
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0] H_ACT  = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_ACT  = POS_W'(V_ACTIVE);
    localparam logic [POS_W-1:0] HS_BEG = POS_W'(H_ACTIVE + H_FP);
    localparam logic [POS_W-1:0] HS_END = POS_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [POS_W-1:0] VS_BEG = POS_W'(V_ACTIVE + V_FP);
    localparam logic [POS_W-1:0] VS_END = POS_W'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE > 2048 || H_TOTAL > 4096 || V_TOTAL > 4096 ||
        PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_param_err
        $error("video_timing_gen: raster or PIPE_DLY out of range");
    end

    logic [POS_W-1:0] h_pos, v_pos;
    logic [POS_W-1:0] nxt_h, nxt_v;
    logic             nxt_de, nxt_hs, nxt_vs, nxt_fs;
    logic             hs_raw, vs_raw, de_raw;
    logic [2:0]       sync_q;

    // next raster position and the raw timing it implies; outputs are
    // registered from these so they describe the position held this cycle
    always_comb begin
        nxt_h = (h_pos == H_LAST) ? '0 : h_pos + 1'b1;
        nxt_v = v_pos;
        if (h_pos == H_LAST) nxt_v = (v_pos == V_LAST) ? '0 : v_pos + 1'b1;
        nxt_de = (nxt_h < H_ACT) && (nxt_v < V_ACT);
        nxt_hs = (nxt_h >= HS_BEG) && (nxt_h < HS_END);
        nxt_vs = (nxt_v >= VS_BEG) && (nxt_v < VS_END);
        nxt_fs = (nxt_h == '0) && (nxt_v == '0);
    end

    // position counters, coordinates, raw syncs and frame bookkeeping;
    // reset parks at the last position so release wraps into frame 0
    always_ff @(posedge clk) begin
        if (rst) begin
            h_pos       <= H_LAST;
            v_pos       <= V_LAST;
            hcnt        <= '0;
            vcnt        <= '0;
            mode        <= '0;
            hs_raw      <= 1'b0;
            vs_raw      <= 1'b0;
            de_raw      <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'hFF;
        end else if (en) begin
            h_pos       <= nxt_h;
            v_pos       <= nxt_v;
            hcnt        <= nxt_de ? nxt_h[HCNT_W-1:0] : '0;
            vcnt        <= nxt_de ? nxt_v : '0;
            hs_raw      <= nxt_hs;
            vs_raw      <= nxt_vs;
            de_raw      <= nxt_de;
            frame_start <= nxt_fs;
            if (nxt_fs) begin
                mode      <= mode_in;
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    sync_delay_line #(.DEPTH(PIPE_DLY), .W(3)) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   ({hs_raw, vs_raw, de_raw}),
        .q   (sync_q)
    );

    assign {hsync, vsync, de} = sync_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small raster checked against a linear-index
// reference model through a scoreboard, plus a 1080p line-timing pass.
module tb_video_timing_gen;

    localparam int HT = 16, VT = 8, TOT = HT * VT;

    typedef struct packed {
        logic [10:0] hcnt;
        logic [11:0] vcnt;
        logic [3:0]  mode;
        logic        hs, vs, de, fs;
        logic [7:0]  fc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1, en = 1'b1, rst_b = 1'b1;
    logic [3:0]  mode_in = 4'd0;
    logic [10:0] hcnt, hcnt_b;
    logic [11:0] vcnt, vcnt_b;
    logic [3:0]  mode, mode_b;
    logic        hsync, vsync, de, frame_start;
    logic        hsync_b, vsync_b, de_b, frame_start_b;
    logic [7:0]  frame_cnt, frame_cnt_b;

    int checks = 0, failures = 0, cyc = -1;
    obs_t sb[$];
    obs_t exp_o, got_o;

    // reference model state: linear position within the frame
    int p;
    logic [7:0] m_fc;
    logic [3:0] m_mode;
    logic r_hs, r_vs, r_de, d_hs, d_vs, d_de, m_fs;
    logic [10:0] m_h;
    logic [11:0] m_v;

    always #5 clk = ~clk;

    video_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                       .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                       .PIPE_DLY(1)) dut (
        .clk(clk), .rst(rst), .en(en), .mode_in(mode_in),
        .hcnt(hcnt), .vcnt(vcnt), .mode(mode), .hsync(hsync), .vsync(vsync),
        .de(de), .frame_start(frame_start), .frame_cnt(frame_cnt));

    video_timing_gen u_big (
        .clk(clk), .rst(rst_b), .en(en), .mode_in(mode_in),
        .hcnt(hcnt_b), .vcnt(vcnt_b), .mode(mode_b), .hsync(hsync_b),
        .vsync(vsync_b), .de(de_b), .frame_start(frame_start_b),
        .frame_cnt(frame_cnt_b));

    function automatic obs_t got_obs();
        return {hcnt, vcnt, mode, hsync, vsync, de, frame_start, frame_cnt};
    endfunction

    task automatic model_update();
        int h, v;
        if (rst) begin
            p = TOT - 1; m_fc = 8'hFF; m_mode = 4'd0; m_fs = 1'b0;
            r_hs = 0; r_vs = 0; r_de = 0; d_hs = 0; d_vs = 0; d_de = 0;
            m_h = '0; m_v = '0;
        end else if (en) begin
            d_hs = r_hs; d_vs = r_vs; d_de = r_de;
            p = (p + 1) % TOT;
            h = p % HT; v = p / HT;
            r_de = (h < 8) && (v < 4);
            r_hs = (h >= 10) && (h < 13);
            r_vs = (v >= 5) && (v < 7);
            m_fs = (p == 0);
            if (m_fs) begin m_fc = m_fc + 8'd1; m_mode = mode_in; end
            m_h = r_de ? 11'(h) : 11'd0;
            m_v = r_de ? 12'(v) : 12'd0;
        end
    endtask

    // one clock: model follows the DUT edge, expectation queued, then
    // return at the falling edge ready for sampling and the next drive
    task automatic tick();
        @(posedge clk);
        model_update();
        sb.push_back({m_h, m_v, m_mode, d_hs, d_vs, d_de, m_fs, m_fc});
        cyc = rst ? -1 : cyc + 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; mode_in = 4'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_o = sb.pop_front(); got_o = got_obs(); checks++;
            if (got_o !== exp_o) begin failures++;
                $display("FAIL reset_sb i=%0d got=%h exp=%h", i, got_o, exp_o); end
        end
        checks++;
        if (got_o !== {11'd0, 12'd0, 4'd0, 4'b0000, 8'hFF}) begin failures++;
            $display("FAIL reset_state got=%h exp=%h", got_o,
                     {11'd0, 12'd0, 4'd0, 4'b0000, 8'hFF}); end
        mode_in = 4'd0;
    endtask

    task automatic test_frame();
        rst = 1'b0;
        for (int i = 0; i < 260; i++) begin
            if (cyc == 39)  mode_in = 4'd2;
            if (cyc == 129) mode_in = 4'd1;
            tick();
            exp_o = sb.pop_front(); got_o = got_obs(); checks++;
            if (got_o !== exp_o) begin failures++;
                $display("FAIL frame_sb cyc=%0d got=%h exp=%h", cyc, got_o, exp_o); end
            if (cyc == 0) begin checks++;
                if ({frame_start, frame_cnt, hcnt, vcnt} !== {1'b1, 8'd0, 11'd0, 12'd0}) begin
                    failures++; $display("FAIL first_cycle fs=%b fc=%0d h=%0d v=%0d exp 1/0/0/0",
                                         frame_start, frame_cnt, hcnt, vcnt); end end
            if (cyc == 1) begin checks++;
                if (de !== 1'b1) begin failures++; $display("FAIL de_first got=%b exp=1", de); end end
            if (cyc == 7) begin checks++;
                if (hcnt !== 11'd7) begin failures++; $display("FAIL hcnt_last got=%0d exp=7", hcnt); end end
            if (cyc == 8) begin checks++;
                if (hcnt !== 11'd0 || de !== 1'b1) begin failures++;
                    $display("FAIL hcnt_wrap h=%0d de=%b exp 0/1", hcnt, de); end end
            if (cyc == 10 || cyc == 14) begin checks++;
                if (hsync !== 1'b0) begin failures++; $display("FAIL hsync_off cyc=%0d got=%b exp=0", cyc, hsync); end end
            if (cyc == 11 || cyc == 13) begin checks++;
                if (hsync !== 1'b1) begin failures++; $display("FAIL hsync_on cyc=%0d got=%b exp=1", cyc, hsync); end end
            if (cyc == 80 || cyc == 113) begin checks++;
                if (vsync !== 1'b0) begin failures++; $display("FAIL vsync_off cyc=%0d got=%b exp=0", cyc, vsync); end end
            if (cyc == 81 || cyc == 112) begin checks++;
                if (vsync !== 1'b1) begin failures++; $display("FAIL vsync_on cyc=%0d got=%b exp=1", cyc, vsync); end end
            if (cyc == 127) begin checks++;
                if (mode !== 4'd0 || frame_start !== 1'b0) begin failures++;
                    $display("FAIL pre_boundary mode=%0d fs=%b exp 0/0", mode, frame_start); end end
            if (cyc == 128) begin checks++;
                if ({frame_start, frame_cnt, mode} !== {1'b1, 8'd1, 4'd2}) begin failures++;
                    $display("FAIL frame2 fs=%b fc=%0d mode=%0d exp 1/1/2", frame_start, frame_cnt, mode); end end
            if (cyc == 256) begin checks++;
                if ({frame_cnt, mode} !== {8'd2, 4'd1}) begin failures++;
                    $display("FAIL frame3 fc=%0d mode=%0d exp 2/1", frame_cnt, mode); end end
        end
    endtask

    task automatic test_enable();
        rst = 1'b1; tick(); void'(sb.pop_front());
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            en = !((cyc + 1) >= 20 && (cyc + 1) <= 24);
            tick();
            exp_o = sb.pop_front(); got_o = got_obs(); checks++;
            if (got_o !== exp_o) begin failures++;
                $display("FAIL enable_sb cyc=%0d got=%h exp=%h", cyc, got_o, exp_o); end
            if (cyc == 22) begin checks++;
                if ({hcnt, vcnt, de} !== {11'd3, 12'd1, 1'b1}) begin failures++;
                    $display("FAIL frozen h=%0d v=%0d de=%b exp 3/1/1", hcnt, vcnt, de); end end
            if (cyc == 25) begin checks++;
                if ({hcnt, vcnt} !== {11'd4, 12'd1}) begin failures++;
                    $display("FAIL resume h=%0d v=%0d exp 4/1", hcnt, vcnt); end end
        end
        en = 1'b1;
    endtask

    task automatic test_midframe_reset();
        rst = 1'b1; tick(); void'(sb.pop_front());
        rst = 1'b0;
        for (int i = 0; i < 90; i++) begin
            rst = (cyc == 59);
            tick();
            exp_o = sb.pop_front(); got_o = got_obs(); checks++;
            if (got_o !== exp_o) begin failures++;
                $display("FAIL midrst_sb cyc=%0d got=%h exp=%h", cyc, got_o, exp_o); end
            if (rst) begin checks++;
                if ({frame_cnt, hcnt, vcnt, hsync, vsync, de} !== {8'hFF, 23'd0, 3'b000}) begin
                    failures++; $display("FAIL midrst_state fc=%h h=%0d v=%0d sync=%b%b%b exp ff/0/0/000",
                                         frame_cnt, hcnt, vcnt, hsync, vsync, de); end
            end else if (cyc == 0 && i > 0) begin checks++;
                if ({frame_start, frame_cnt} !== {1'b1, 8'd0}) begin failures++;
                    $display("FAIL midrst_restart fs=%b fc=%0d exp 1/0", frame_start, frame_cnt); end
            end
        end
    endtask

    task automatic test_1080p();
        int hs_n, hs_first;
        hs_n = 0; hs_first = -1;
        rst_b = 1'b0;
        for (int i = 0; i < 2300; i++) begin
            @(posedge clk); @(negedge clk);
            if (i < 2200 && hsync_b === 1'b1) begin
                hs_n++; if (hs_first < 0) hs_first = i; end
            if (i == 0) begin checks++;
                if ({frame_start_b, hcnt_b, vcnt_b, de_b} !== {1'b1, 23'd0, 1'b0}) begin failures++;
                    $display("FAIL big_origin fs=%b h=%0d v=%0d de=%b exp 1/0/0/0",
                             frame_start_b, hcnt_b, vcnt_b, de_b); end end
            if (i == 1 || i == 1920 || i == 2201) begin checks++;
                if (de_b !== 1'b1) begin failures++; $display("FAIL big_de_on i=%0d got=%b exp=1", i, de_b); end end
            if (i == 1921 || i == 2200) begin checks++;
                if (de_b !== 1'b0) begin failures++; $display("FAIL big_de_off i=%0d got=%b exp=0", i, de_b); end end
            if (i == 1919) begin checks++;
                if ({hcnt_b, vcnt_b} !== {11'd1919, 12'd0}) begin failures++;
                    $display("FAIL big_last_px h=%0d v=%0d exp 1919/0", hcnt_b, vcnt_b); end end
            if (i == 2200) begin checks++;
                if ({hcnt_b, vcnt_b, frame_start_b} !== {11'd0, 12'd1, 1'b0}) begin failures++;
                    $display("FAIL big_line1 h=%0d v=%0d fs=%b exp 0/1/0", hcnt_b, vcnt_b, frame_start_b); end end
        end
        checks++;
        if (hs_n != 44 || hs_first != 2009) begin failures++;
            $display("FAIL big_hsync width=%0d first=%0d exp 44/2009", hs_n, hs_first); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_frame();
        test_enable();
        test_midframe_reset();
        test_1080p();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
